mem_stage_sequencer: RTL and testbench
======================================

Name: mem_stage_sequencer

Overview:
- Sequences the memory stage between the EX/MEM buffer and a single 16-bit data memory port.
- Splits one pipeline memory operation into 1–3 word accesses:
  - plain MR/MW: one data word;
  - CALL/INT push or RET/RTI pop: PC[31:16], PC[15:0], and a flags word.
- Drives the memory handshake and stalls the pipeline until the whole sequence completes.
- Returns the assembled read data and flags to the writeback/PC/flag-register paths.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 16, memory word width
- TIMEOUT_CYCLES, 15, max wait cycles per word (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  EX/MEM holds a memory operation
- req_mr  in  1  read (MR_Out)
- req_mw  in  1  write (MW_Out)
- req_stack_pc  in  1  include 32-bit PC (Stack_PC_Out)
- req_stack_flags  in  1  include flags word (Stack_Flags_Out)
- req_addr  in  ADDR_W  base address (Address)
- req_data  in  32  write data / PC (Data)
- req_flags  in  3  NF|CF|ZF to push (Final_Flags)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  current word completes this cycle
- stall  out  1  freeze IF/ID/EX and EX/MEM buffers
- done  out  1  one-cycle completion pulse
- rd_data  out  32  assembled read result
- rd_flags  out  3  popped flags
- err_illegal  out  1  one-cycle pulse: req_mr and req_mw both set
- err_timeout  out  1  one-cycle pulse: word timed out

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state, counters and registered outputs update on rising clk.
  - reset is synchronous, active-high.
  - Reset values: state IDLE; mem_addr 0; mem_wdata 0; mem_re 0; mem_we 0; done 0; rd_data 0; rd_flags 0; err_illegal 0; err_timeout 0.
  - stall is 0 in reset state.
- States: IDLE, ACCESS, DONE.
- Word list (N = 1..3, built at accept):
  - flags word {13'b0, flags} if req_stack_flags;
  - then PC[31:16] and PC[15:0] if req_stack_pc;
  - plain data word req_data[15:0] if neither flag is set.
  - Word k goes to address req_addr + k, modulo 2^ADDR_W (wraps).
- IDLE:
  - Valid request is req_valid & (req_mr ^ req_mw).
  - On a valid request: latch all req_* fields, load word 0 onto mem_addr/mem_wdata, set mem_re or mem_we, go to ACCESS.
  - req_valid with both mr and mw set: no access; err_illegal pulses next cycle; stay in IDLE.
  - req_valid with neither set: ignored.
- ACCESS:
  - mem_addr, mem_wdata, mem_re and mem_we are held stable until mem_ready is sampled high.
  - On a ready read: capture mem_rdata into the matching slot. Flags word → rd_flags = mem_rdata[2:0]; PC high/low → rd_data[31:16] and rd_data[15:0]; plain word → rd_data = {16'b0, mem_rdata}.
  - If words remain: the next word is presented the following cycle.
  - After the last word: drop strobes and go to DONE.
  - With mem_ready tied high, an N-word operation takes N ACCESS cycles.
- DONE:
  - done = 1 for exactly one cycle; rd_data and rd_flags are valid and held until the next accept.
  - Return to IDLE; no request is accepted in DONE.
- Stall:
  - stall = (IDLE & valid request) | ACCESS. This is combinational so the pipeline freezes the same cycle.
  - stall is 0 in DONE so the pipeline advances exactly once.
- Reset mid-operation: abort to IDLE; strobes low after the edge; no done pulse; latched request discarded.
- mem_ready while idle is ignored.
- Write sequences leave rd_data and rd_flags unchanged.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A per-word wait counter clears on each new word and increments every ACCESS cycle while mem_ready is low.
  - When it reaches TIMEOUT_CYCLES: abort the remaining words, pulse err_timeout with done in DONE, and zero the rd_data/rd_flags slots not yet read.
- Not defined: counter absent; waits indefinitely; err_timeout tied 0.

Test Plan:
1. MR, addr=0x20, mem_ready=1, mem_rdata=0x1234 → one ACCESS cycle with mem_re=1, mem_addr=0x20; done next cycle; rd_data=0x00001234; stall high for 2 cycles.
2. MW + stack_pc + stack_flags, addr=0x100, data=0x000A0015, flags=3'b101, ready=1 → writes in order: 0x100←0x0005, 0x101←0x000A, 0x102←0x0015; done once; stall high 4 cycles.
3. MR + stack_pc, addr=0xFFFFFFFF, ready delayed 2 cycles per word, rdata 0xBEEF then 0x0042 → second address wraps to 0x0; strobes and address held during waits; rd_data=0xBEEF0042.
4. req_mr=req_mw=1 → no strobe; err_illegal pulses once; stall low; state stays IDLE.
5. reset asserted during the second word of a 3-word push → strobes 0 after the edge; no done; next request starts at word 0.
6. With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=3, mem_ready=0 → mem_re held for 3 cycles; then err_timeout=1, done=1, rd_data=0.

Source files
------------

// File: rtl/mem_stage_sequencer.sv
// rtl/mem_stage_sequencer.sv - memory-stage word sequencer (1-3 words per op); optional per-word timeout under MEM_TIMEOUT_EN
module mem_stage_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_mr,
  input  logic              req_mw,
  input  logic              req_stack_pc,
  input  logic              req_stack_flags,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [2:0]        req_flags,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rd_data,
  output logic [2:0]        rd_flags,
  output logic              err_illegal,
  output logic              err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {W_PLAIN, W_FLAGS, W_PC_HI, W_PC_LO} kind_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] wl_data [3];
  kind_t             wl_kind [3];
  logic [1:0]        wl_n;

  logic [DATA_W-1:0] word_q [3];
  kind_t             kind_q [3];
  logic [1:0]        n_q;
  logic [1:0]        idx_q;
  logic [ADDR_W-1:0] base_q;
  logic              read_q;

  logic accept;
  logic illegal;
  logic last_word;
  logic timeout_hit;

  assign accept    = req_valid & (req_mr ^ req_mw);
  assign illegal   = req_valid & req_mr & req_mw;
  assign last_word = (idx_q == (n_q - 2'd1));

  // Word order: flags first, then PC high, then PC low; plain data when neither.
  always_comb begin
    wl_data = '{default: '0};
    wl_kind = '{default: W_PLAIN};
    wl_n    = 2'd1;
    if (req_stack_flags) begin
      wl_data[0] = DATA_W'(req_flags);
      wl_kind[0] = W_FLAGS;
      if (req_stack_pc) begin
        wl_data[1] = DATA_W'(req_data[31:16]);
        wl_kind[1] = W_PC_HI;
        wl_data[2] = DATA_W'(req_data[15:0]);
        wl_kind[2] = W_PC_LO;
        wl_n       = 2'd3;
      end
    end else if (req_stack_pc) begin
      wl_data[0] = DATA_W'(req_data[31:16]);
      wl_kind[0] = W_PC_HI;
      wl_data[1] = DATA_W'(req_data[15:0]);
      wl_kind[1] = W_PC_LO;
      wl_n       = 2'd2;
    end else begin
      wl_data[0] = DATA_W'(req_data[15:0]);
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q;

  assign timeout_hit = (state_q == S_ACCESS) && !mem_ready &&
                       (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts whenever a new word is presented (accept or completed word).
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (state_q != S_ACCESS || mem_ready) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = accept;
        if (accept) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if ((mem_ready && last_word) || timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      done        <= 1'b0;
      rd_data     <= '0;
      rd_flags    <= '0;
      err_illegal <= 1'b0;
      word_q      <= '{default: '0};
      kind_q      <= '{default: W_PLAIN};
      n_q         <= 2'd1;
      idx_q       <= '0;
      base_q      <= '0;
      read_q      <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_illegal <= 1'b0;
      case (state_q)
        S_IDLE: begin
          err_illegal <= illegal;
          if (accept) begin
            word_q    <= wl_data;
            kind_q    <= wl_kind;
            n_q       <= wl_n;
            idx_q     <= '0;
            base_q    <= req_addr;
            read_q    <= req_mr;
            mem_addr  <= req_addr;
            mem_wdata <= wl_data[0];
            mem_re    <= req_mr;
            mem_we    <= req_mw;
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            if (read_q) begin
              case (kind_q[idx_q])
                W_PLAIN: rd_data         <= 32'(mem_rdata);
                W_FLAGS: rd_flags        <= mem_rdata[2:0];
                W_PC_HI: rd_data[31:16]  <= mem_rdata[15:0];
                W_PC_LO: rd_data[15:0]   <= mem_rdata[15:0];
                default: ;
              endcase
            end
            if (last_word) begin
              mem_re <= 1'b0;
              mem_we <= 1'b0;
              done   <= 1'b1;
            end else begin
              idx_q     <= idx_q + 2'd1;
              mem_addr  <= base_q + ADDR_W'(idx_q + 2'd1);
              mem_wdata <= word_q[idx_q + 2'd1];
            end
          end else if (timeout_hit) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            done   <= 1'b1;
            // Slots this read never reached must not leak stale data.
            if (read_q) begin
              for (int k = 0; k < 3; k++) begin
                if (k >= int'(idx_q) && k < int'(n_q)) begin
                  case (kind_q[k])
                    W_PLAIN: rd_data        <= '0;
                    W_FLAGS: rd_flags       <= '0;
                    W_PC_HI: rd_data[31:16] <= '0;
                    W_PC_LO: rd_data[15:0]  <= '0;
                    default: ;
                  endcase
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// tb/tb_mem_stage_sequencer.sv - scoreboard bench for mem_stage_sequencer (timeout scenario under MEM_TIMEOUT_EN)
module tb_mem_stage_sequencer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 3;
`else
  localparam int TMO = 15;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_mr = 1'b0;
  logic              req_mw = 1'b0;
  logic              req_stack_pc = 1'b0;
  logic              req_stack_flags = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_data = '0;
  logic [2:0]        req_flags = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              stall;
  logic              done;
  logic [31:0]       rd_data;
  logic [2:0]        rd_flags;
  logic              err_illegal;
  logic              err_timeout;

  always #5 clk = ~clk;

  mem_stage_sequencer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_mr(req_mr),
    .req_mw(req_mw),
    .req_stack_pc(req_stack_pc),
    .req_stack_flags(req_stack_flags),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_flags(req_flags),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall(stall),
    .done(done),
    .rd_data(rd_data),
    .rd_flags(rd_flags),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        we;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    logic        tmo;
  } res_t;

  acc_t        exp_acc [$];
  res_t        exp_res [$];
  logic [15:0] rdata_q [$];
  acc_t        mon_acc;
  res_t        mon_res;

  int checks = 0;
  int errors = 0;

  int ready_delay = 0;
  bit stuck = 1'b0;
  bit idle_ready = 1'b0;

  logic [31:0] m_data = '0;
  logic [2:0]  m_flags = '0;

  bit          prev_strobe = 1'b0;
  bit          prev_ready = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_wdata = '0;
  logic        prev_re = 1'b0;
  logic        prev_we = 1'b0;
  int          waited = 0;

  // Memory responder: holds off ready for ready_delay cycles per word, checks the word stays stable.
  always @(posedge clk) begin
    #1;
    if ((mem_re || mem_we) && prev_strobe && !prev_ready && !reset) begin
      checks++;
      if (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_re !== prev_re || mem_we !== prev_we) begin
        errors++;
        $display("FAIL hold: addr %h re %b we %b wdata %h, required addr %h re %b we %b wdata %h",
                 mem_addr, mem_re, mem_we, mem_wdata, prev_addr, prev_re, prev_we, prev_wdata);
      end
      waited++;
    end else begin
      waited = 0;
    end
    if (mem_re || mem_we) mem_ready = !stuck && (waited >= ready_delay);
    else mem_ready = idle_ready;
    mem_rdata   = (rdata_q.size() > 0) ? rdata_q[0] : 16'hdead;
    prev_strobe = mem_re || mem_we;
    prev_ready  = mem_ready;
    prev_addr   = mem_addr;
    prev_wdata  = mem_wdata;
    prev_re     = mem_re;
    prev_we     = mem_we;
  end

  // Scoreboard: completed memory words and done pulses are popped against expectations.
  always @(negedge clk) begin
    if (!reset) begin
      if ((mem_re || mem_we) && mem_ready) begin
        checks++;
        if (exp_acc.size() == 0) begin
          errors++;
          $display("FAIL access_unexpected: addr %h re %b we %b, required no access", mem_addr, mem_re, mem_we);
        end else begin
          mon_acc = exp_acc.pop_front();
          if (mem_addr !== mon_acc.addr || mem_we !== mon_acc.we || mem_re !== !mon_acc.we ||
              (mon_acc.we && mem_wdata !== mon_acc.wdata)) begin
            errors++;
            $display("FAIL access: addr %h re %b we %b wdata %h, required addr %h we %b wdata %h",
                     mem_addr, mem_re, mem_we, mem_wdata, mon_acc.addr, mon_acc.we, mon_acc.wdata);
          end
        end
        if (mem_re && rdata_q.size() > 0) void'(rdata_q.pop_front());
      end
      if (done) begin
        checks++;
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done %b, required 0", done);
        end else begin
          mon_res = exp_res.pop_front();
          if (rd_data !== mon_res.data || rd_flags !== mon_res.flags || err_timeout !== mon_res.tmo) begin
            errors++;
            $display("FAIL result: rd_data %h rd_flags %b err_timeout %b, required %h %b %b",
                     rd_data, rd_flags, err_timeout, mon_res.data, mon_res.flags, mon_res.tmo);
          end
        end
      end
    end
  end

  task automatic run_op(input string name, input logic mr, input logic mw, input logic pc, input logic fl,
                        input logic [31:0] addr, input logic [31:0] data, input logic [2:0] flags,
                        input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                        input int delay, input bit tmo);
    logic [15:0] w [3];
    int          kd [3];
    logic [15:0] rv [3];
    logic [15:0] v;
    int          n;
    int          exp_stall;
    int          stall_cnt;
    int          strobe_cnt;
    bit          got;
    acc_t        a;
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    n = 0;
    if (fl) begin w[n] = {13'b0, flags}; kd[n] = 1; n++; end
    if (pc) begin
      w[n] = data[31:16]; kd[n] = 2; n++;
      w[n] = data[15:0];  kd[n] = 3; n++;
    end
    if (!fl && !pc) begin w[0] = data[15:0]; kd[0] = 0; n = 1; end
    for (int k = 0; k < n; k++) begin
      if (!tmo) begin
        a.addr = addr + 32'(k); a.wdata = w[k]; a.we = mw;
        exp_acc.push_back(a);
        if (mr) rdata_q.push_back(rv[k]);
      end
      if (mr) begin
        v = tmo ? 16'h0 : rv[k];
        case (kd[k])
          0: m_data = {16'h0, v};
          1: m_flags = v[2:0];
          2: m_data[31:16] = v;
          default: m_data[15:0] = v;
        endcase
      end
    end
    exp_res.push_back('{m_data, m_flags, tmo});
    exp_stall = 1 + (tmo ? TMO : n * (delay + 1));
    ready_delay = delay;
    stuck = tmo;

    req_mr = mr; req_mw = mw; req_stack_pc = pc; req_stack_flags = fl;
    req_addr = addr; req_data = data; req_flags = flags; req_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_on_request: got %b, required 1", name, stall);
    end
    @(posedge clk); #2;
    req_valid = 1'b0; req_data = ~data; req_addr = ~addr; req_flags = ~flags;
    stall_cnt = 1; strobe_cnt = 0; got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      if (stall === 1'b1) stall_cnt++;
      if (mem_re === 1'b1 || mem_we === 1'b1) strobe_cnt++;
      @(posedge clk); #2;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_wait: no done within 100 cycles, required done", name);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", name, stall_cnt, exp_stall);
    end
    checks++;
    if (strobe_cnt != exp_stall - 1) begin
      errors++;
      $display("FAIL %s strobe_cycles: got %0d, required %0d", name, strobe_cnt, exp_stall - 1);
    end
    checks++;
    if (stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: stall %b re %b we %b, required 0 0 0", name, stall, mem_re, mem_we);
    end
    @(posedge clk); #2;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: got %b, required 0", name, done);
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_re !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
        rd_data !== '0 || rd_flags !== '0 || err_illegal !== 1'b0 || err_timeout !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: addr %h wdata %h re %b we %b done %b rd %h fl %b ill %b tmo %b stall %b, required all 0",
               mem_addr, mem_wdata, mem_re, mem_we, done, rd_data, rd_flags, err_illegal, err_timeout, stall);
    end
    reset = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_plain();
    run_op("mr_plain", 1, 0, 0, 0, 32'h20, 32'h0, 3'b0, 16'h1234, 16'h0, 16'h0, 0, 0);
    run_op("mw_plain", 0, 1, 0, 0, 32'h24, 32'h5555_abcd, 3'b0, 16'h0, 16'h0, 16'h0, 1, 0);
  endtask

  task automatic test_push();
    run_op("push3", 0, 1, 1, 1, 32'h100, 32'h000A_0015, 3'b101, 16'h0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic test_pop();
    run_op("pop_pc_wrap", 1, 0, 1, 0, 32'hFFFF_FFFF, 32'h0, 3'b0, 16'hBEEF, 16'h0042, 16'h0, 2, 0);
    run_op("pop_rti", 1, 0, 1, 1, 32'h200, 32'h0, 3'b0, 16'h0006, 16'h1111, 16'h2222, 1, 0);
  endtask

  task automatic test_illegal();
    idle_ready = 1'b1;
    req_mr = 1'b1; req_mw = 1'b1; req_stack_pc = 1'b0; req_stack_flags = 1'b0; req_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL illegal_stall: got %b, required 0", stall);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    checks++;
    if (err_illegal !== 1'b1 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: err %b re %b we %b, required 1 0 0", err_illegal, mem_re, mem_we);
    end
    @(posedge clk); #2;
    checks++;
    if (err_illegal !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after: err %b done %b re %b we %b, required 0 0 0 0", err_illegal, done, mem_re, mem_we);
    end
    req_mr = 1'b0; req_mw = 1'b0; req_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL noop_stall: got %b, required 0", stall);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0 || err_illegal !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL noop_ignored: re %b we %b err %b done %b, required 0 0 0 0", mem_re, mem_we, err_illegal, done);
    end
    idle_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    acc_t a;
    a.addr = 32'h300; a.wdata = 16'h0003; a.we = 1'b1;
    exp_acc.push_back(a);
    ready_delay = 0;
    req_mr = 1'b0; req_mw = 1'b1; req_stack_pc = 1'b1; req_stack_flags = 1'b1;
    req_addr = 32'h300; req_data = 32'h7777_8888; req_flags = 3'b011; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: re %b we %b done %b stall %b, required 0 0 0 0", mem_re, mem_we, done, stall);
    end
    reset = 1'b0;
    m_data = '0;
    m_flags = '0;
    @(posedge clk); #2;
    checks++;
    if (done !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: done %b we %b, required 0 0", done, mem_we);
    end
    run_op("push_after_reset", 0, 1, 1, 1, 32'h400, 32'h1234_5678, 3'b110, 16'h0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic mr;
    for (int i = 0; i < 6; i++) begin
      mr = 1'($urandom_range(0, 1));
      run_op("b2b", mr, !mr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, 3'($urandom_range(0, 7)),
             16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 2), 0);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_op("timeout_plain", 1, 0, 0, 0, 32'h40, 32'h0, 3'b0, 16'h0, 16'h0, 16'h0, 0, 1);
    run_op("timeout_rti", 1, 0, 1, 1, 32'h80, 32'h0, 3'b0, 16'h0, 16'h0, 16'h0, 0, 1);
    run_op("after_timeout", 1, 0, 0, 0, 32'h44, 32'h0, 3'b0, 16'h5a5a, 16'h0, 16'h0, 0, 0);
  endtask
`endif

  task automatic test_drain();
    checks++;
    if (exp_acc.size() != 0 || exp_res.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d accesses and %0d results outstanding, required 0 0", exp_acc.size(), exp_res.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plain();
    test_push();
    test_pop();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge clk);
    #2;
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
